inst_fetch_unit: RTL

Instruction fetch front end for the 32-bit MIPS core. Holds the PC, issues word reads to instruction memory over a request/grant/valid bus, buffers returned words in a 2-entry queue, and presents {pc, instruction, opcode} to the control unit under a valid/ready handshake. Branch and jump redirects from the execute path flush the queue, discard any in-flight response and restart fetch at the target.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/ifu_fifo.sv | 71 +++++++
 rtl/inst_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: instruction width, primary opcodes
// and the instruction-fetch FSM state type.
package mips_pkg;

    localparam int INST_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifu_state_t;

    function automatic logic [5:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[INST_W-1:INST_W-6];
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry {pc, inst} queue for the fetch unit. Slot 0 is the head and is
// read straight from its registers, so the head outputs are registered.
// count_o reports the occupancy after this cycle's pop/push/flush, which the
// fetch FSM uses to decide whether another request fits.
module ifu_fifo
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [INST_W-1:0] head_inst_o
);

    logic [ADDR_W-1:0] pc_q   [2];
    logic [ADDR_W-1:0] pc_d   [2];
    logic [INST_W-1:0] inst_q [2];
    logic [INST_W-1:0] inst_d [2];
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;

    // Next queue contents: pop shifts slot 1 forward, then push fills the first free slot.
    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            if (pop_i && cnt_q != 2'd0) begin
                pc_d[0]   = pc_q[1];
                inst_d[0] = inst_q[1];
                cnt_d     = cnt_q - 2'd1;
            end
            if (push_i && cnt_d != 2'd2) begin
                pc_d[cnt_d[0]]   = push_pc_i;
                inst_d[cnt_d[0]] = push_inst_i;
                cnt_d            = cnt_d + 2'd1;
            end
        end
    end

    // Queue storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q[0]   <= '0;
            pc_q[1]   <= '0;
            inst_q[0] <= '0;
            inst_q[1] <= '0;
            cnt_q     <= '0;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count_o      = cnt_d;
    assign head_valid_o = (cnt_q != 2'd0);
    assign head_pc_o    = pc_q[0];
    assign head_inst_o  = inst_q[0];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem request FSM,
// 2-entry instruction queue and redirect/flush handling.
// Optional feature macro: IFU_PERF_CNT_EN adds the ifu_fetch_cnt output,
// a saturating count of instructions pushed into the queue.
module inst_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       ifu_fetch_cnt
`endif
);

    localparam logic [ADDR_W-1:0] RESET_PC_AL = RESET_PC & ~ADDR_W'(3);

    ifu_state_t        state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] fetch_pc_d;
    logic              drop_q;
    logic              drop_d;
    logic              imem_req_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic              push;
    logic              pop;
    logic [1:0]        count_nxt;

    // A response is kept only if it belongs to the current fetch stream.
    assign push = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect;
    assign pop  = if_valid && if_ready;

    // Next fetch PC and drop flag; a redirect overrides the normal increment.
    // While drop_q is set in REQ, the pending grant is for a stale address,
    // so it must not advance fetch_pc past the redirect target.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (state_q == REQ && imem_gnt && !drop_q) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (redirect) begin
            // A response landing in the redirect cycle is discarded directly.
            drop_d = (state_q == REQ) || (state_q == WAIT && !imem_rvalid);
        end else if (state_q == WAIT && imem_rvalid) begin
            drop_d = 1'b0;
        end
    end

    // Fetch FSM with registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC_AL;
            drop_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC_AL;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            unique case (state_q)
                IDLE: begin
                    if (count_nxt != 2'd2) begin
                        state_q     <= REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_d;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_q    <= WAIT;
                        imem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (count_nxt != 2'd2) begin
                            state_q     <= REQ;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= fetch_pc_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;

    // imem_addr_q holds the granted address through WAIT, so it tags the response.
    ifu_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_pc_i    (imem_addr_q),
        .push_inst_i  (imem_rdata),
        .pop_i        (pop),
        .flush_i      (redirect),
        .count_o      (count_nxt),
        .head_valid_o (if_valid),
        .head_pc_o    (if_pc),
        .head_inst_o  (if_inst)
    );

    assign if_opcode = opcode_of(if_inst);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Saturating count of instructions accepted into the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
        end else if (push && fetch_cnt_q != '1) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign ifu_fetch_cnt = fetch_cnt_q;
`endif

endmodule
